// File: rtl/mem_responder_pkg.sv
// Shared types for the valid/ready memory request bus and the responder FSM.
// Imported by the responder top and its RAM.
package mem_responder_pkg;

  localparam int XLEN  = 32;
  localparam int NBE   = XLEN / 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic            valid;
    logic            instr;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [NBE-1:0]  wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            ready;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_type;

  function automatic logic is_read(input logic [NBE-1:0] wstrb);
    return wstrb == '0;
  endfunction

endpackage

// File: rtl/mem_responder_ram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port,
// written in the shape FPGA tools map onto block RAM.
module ram_be
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [NBE-1:0]        we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);

  logic [XLEN-1:0] mem [2**DEPTH_LOG2];

  // NOTE: no reset on the array or read register; a reset port here would
  // stop block RAM inference, and the contents are defined by writes only.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NBE; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, programmable wait states,
// byte-strobed writes into ram_be, out-of-range accesses silently absorbed.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 14,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic [NBE-1:0]    mem_wstrb,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_ready
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_resp_state_type    state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  capture;
  logic                  ram_en;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic [XLEN-1:0]       wdata_q;
  logic [NBE-1:0]        wstrb_q;
  logic                  in_range_q;
  logic                  instr_unused_q;

  logic [XLEN:0]         offset;
  logic                  in_range;
  logic [NBE-1:0]        ram_we;
  logic [XLEN-1:0]       ram_rdata;

  // The extra borrow bit flags addresses below BASE_ADDR.
  assign offset   = {1'b0, mem_addr} - {1'b0, BASE_ADDR};
  assign in_range = !offset[XLEN] && ((offset[XLEN-1:0] >> (DEPTH_LOG2 + 2)) == '0);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    ram_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          capture = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          ram_en  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (mem_valid) begin
          capture = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      cnt_d = CNT_LOAD;
    end
    // A reset landing on the WAIT->RESP edge must not commit the write.
    if (rst) begin
      ram_en = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request payload only matters once accepted, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      idx_q          <= offset[DEPTH_LOG2+1:2];
      wdata_q        <= mem_wdata;
      wstrb_q        <= mem_wstrb;
      in_range_q     <= in_range;
      instr_unused_q <= mem_instr;
    end
  end

  assign ram_we = wstrb_q & {NBE{in_range_q}};

  ram_be #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign mem_ready = (state_q == RESP);
  assign mem_rdata = (mem_ready && in_range_q && is_read(wstrb_q)) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a word-array model.
module tb_mem_responder;

  localparam int N = 5;
  localparam int LAT_OF [N] = '{1, 2, 3, 15, 3};
  localparam logic [31:0] HI_BASE = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      valid;
  logic              instr;
  logic [31:0]       addr, wdata;
  logic [3:0]        wstrb;
  logic [N-1:0]      ready;
  logic [31:0]       rdata [N];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Instances 0..3: BASE 0 with LATENCY 1,2,3,15. Instance 4: high base, LATENCY 3.
  for (genvar g = 0; g < N; g++) begin : gen_dut
    mem_responder #(
      .DEPTH_LOG2 (14),
      .LATENCY    (LAT_OF[g]),
      .BASE_ADDR  (g == 4 ? HI_BASE : 32'h0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mem_valid (valid[g]),
      .mem_instr (instr),
      .mem_addr  (addr),
      .mem_wdata (wdata),
      .mem_wstrb (wstrb),
      .mem_rdata (rdata[g]),
      .mem_ready (ready[g])
    );
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [31:0] e);
    vec_t v;
    v.addr = a; v.wdata = wd; v.wstrb = ws; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request to instance d, holds it until ready (bounded), returns
  // the response data and the number of rising edges from presentation to ready.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, output logic [31:0] rd, output int cyc);
    addr     = a;
    wdata    = wd;
    wstrb    = ws;
    instr    = 1'($urandom_range(0, 1));
    valid[d] = 1'b1;
    cyc      = 0;
    do begin
      tick();
      cyc++;
    end while (ready[d] !== 1'b1 && cyc < 40);
    rd       = rdata[d];
    valid[d] = 1'b0;
  endtask

  task automatic check_txn(input string name, input int d, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input logic [31:0] exp);
    logic [31:0] rd;
    int cyc;
    txn(d, a, wd, ws, rd, cyc);
    check({name, "_data"}, rd, exp);
    check({name, "_lat"}, 32'(cyc), 32'(LAT_OF[d] + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] model [64];
    logic [31:0] rd, a, wd, exp;
    logic [3:0]  ws;
    int          cyc, k;

    valid = '0; instr = 1'b0; addr = '0; wdata = '0; wstrb = '0;

    // Reset held with valid asserted: nothing may respond.
    rst   = 1'b1;
    valid = '1;
    repeat (3) begin
      tick();
      check("rst_ready", 32'(ready), 32'h0);
      check("rst_rdata", rdata[0], 32'h0);
    end
    rst   = 1'b0;
    valid = '0;

    // Directed table on LATENCY=1, BASE 0 (range 0x0..0xFFFF).
    vecs.push_back(mk(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0));
    vecs.push_back(mk(32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEEF));
    vecs.push_back(mk(32'h0000_0100, 32'h1122_3344, 4'b0101, 32'h0));
    vecs.push_back(mk(32'h0000_0100, 32'h0,         4'h0, 32'hDE22_BE44));
    vecs.push_back(mk(32'h0000_0102, 32'h0,         4'h0, 32'hDE22_BE44));
    vecs.push_back(mk(32'h0000_0104, 32'hCAFE_F00D, 4'hF, 32'h0));
    vecs.push_back(mk(32'h0000_0104, 32'h5566_7788, 4'b1010, 32'h0));
    vecs.push_back(mk(32'h0000_0104, 32'h0,         4'h0, 32'h55FE_770D));
    vecs.push_back(mk(32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0));
    vecs.push_back(mk(32'h0001_0000, 32'h1234_5678, 4'hF, 32'h0));
    vecs.push_back(mk(32'h0001_0000, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5));
    vecs.push_back(mk(32'h0000_FFFC, 32'h7777_0001, 4'hF, 32'h0));
    vecs.push_back(mk(32'h0000_FFFC, 32'h0,         4'h0, 32'h7777_0001));
    foreach (vecs[i]) begin
      check_txn($sformatf("vec%0d", i), 0, vecs[i].addr, vecs[i].wdata,
                vecs[i].wstrb, vecs[i].exp);
    end

    // Latency sweep: valid held through WAIT, exactly one ready, none after.
    for (int d = 0; d < 4; d++) begin
      txn(d, 32'h0, 32'h0, 4'h0, rd, cyc);
      check($sformatf("sweep_lat_L%0d", LAT_OF[d]), 32'(cyc), 32'(LAT_OF[d] + 1));
      tick();
      check($sformatf("sweep_quiet_L%0d", LAT_OF[d]), 32'(ready[d]), 32'h0);
    end

    // Back-to-back on LATENCY=2: new address presented in each RESP cycle.
    check_txn("b2b_pre0", 1, 32'h0, 32'd1, 4'hF, 32'h0);
    check_txn("b2b_pre1", 1, 32'h4, 32'd2, 4'hF, 32'h0);
    check_txn("b2b_pre2", 1, 32'h8, 32'd3, 4'hF, 32'h0);
    addr = 32'h0; wdata = '0; wstrb = '0; valid[1] = 1'b1;
    k = 0;
    for (int c = 1; c <= 30 && k < 3; c++) begin
      tick();
      if (ready[1] === 1'b1) begin
        check($sformatf("b2b_data%0d", k), rdata[1], 32'(k + 1));
        check($sformatf("b2b_edge%0d", k), 32'(c), 32'(3 * (k + 1)));
        k++;
        if (k < 3) addr = 32'(4 * k);
        else       valid[1] = 1'b0;
      end
    end
    valid[1] = 1'b0;
    check("b2b_count", 32'(k), 32'd3);
    tick();
    check("b2b_quiet", 32'(ready[1]), 32'h0);

    // High base address, 64 KiB window.
    check_txn("hb_last_wr",  4, 32'h8000_FFFC, 32'h0BAD_CAFE, 4'hF, 32'h0);
    check_txn("hb_last_rd",  4, 32'h8000_FFFC, 32'h0,         4'h0, 32'h0BAD_CAFE);
    check_txn("hb_w0_wr",    4, 32'h8000_0000, 32'h1357_9BDF, 4'hF, 32'h0);
    check_txn("hb_oor_wr",   4, 32'h8001_0000, 32'hFFFF_FFFF, 4'hF, 32'h0);
    check_txn("hb_oor_rd",   4, 32'h8001_0000, 32'h0,         4'h0, 32'h0);
    check_txn("hb_w0_rd",    4, 32'h8000_0000, 32'h0,         4'h0, 32'h1357_9BDF);
    check_txn("hb_below_rd", 4, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0);
    check_txn("hb_old_wr",   4, 32'h8000_0010, 32'h0101_0101, 4'hF, 32'h0);

    // Reset during WAIT: early, and on the edge that would commit the write.
    for (int pre = 0; pre <= 2; pre += 2) begin
      addr = 32'h8000_0010; wdata = 32'hEEEE_EEEE; wstrb = 4'hF;
      valid[4] = 1'b1;
      tick();
      valid[4] = 1'b0;
      repeat (pre) begin
        tick();
        check($sformatf("rstw%0d_wait", pre), 32'(ready[4]), 32'h0);
      end
      rst = 1'b1;
      tick();
      check($sformatf("rstw%0d_in", pre), 32'(ready[4]), 32'h0);
      rst = 1'b0;
      repeat (5) begin
        tick();
        check($sformatf("rstw%0d_after", pre), 32'(ready[4]), 32'h0);
      end
      check_txn($sformatf("rstw%0d_rd", pre), 4, 32'h8000_0010, 32'h0, 4'h0, 32'h0101_0101);
    end

    // Randomized traffic on LATENCY=3 against a 64-word model.
    for (int w = 0; w < 64; w++) begin
      model[w] = $urandom;
      check_txn("rnd_fill", 2, 32'(4 * w), model[w], 4'hF, 32'h0);
    end
    for (int n = 0; n < 200; n++) begin
      int w;
      bit oor;
      w   = $urandom_range(0, 63);
      oor = ($urandom_range(0, 9) < 2);
      a   = oor ? (32'h0001_0000 + 32'(4 * $urandom_range(0, 4000)))
                : (32'(4 * w) + 32'($urandom_range(0, 3)));
      ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      wd  = $urandom;
      if (ws != 4'h0) begin
        exp = 32'h0;
        if (!oor) begin
          for (int b = 0; b < 4; b++) begin
            if (ws[b]) model[w][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end else begin
        exp = oor ? 32'h0 : model[w];
      end
      check_txn($sformatf("rnd%0d", n), 2, a, wd, ws, exp);
    end
    for (int w = 0; w < 64; w++) begin
      check_txn("rnd_final", 2, 32'(4 * w), 32'h0, 4'h0, model[w]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
